// File: rtl/sa_xaddr_channel_if.sv
// ---------------------------------------------------------------------------
// sa_xaddr_channel_if
// Bundles every bus signal of one per-slave address-channel arbiter.
//   dsp_Ax*      : MST_AMT packed dispatcher requests (master m at slice m)
//                  and their one-hot accept dsp_AxREADY_o
//   s_Ax*        : registered address request presented to the slave
//   s_x*         : slave-side data beat handshake (used to retire bursts)
//   sa_*         : burst-ownership information for the slave xDATA arbiter
// Modports:
//   slave  - the arbiter's view (consumes dispatcher requests, drives slave)
//   master - the surrounding environment's view
// ---------------------------------------------------------------------------
interface sa_xaddr_channel_if #(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int MST_ID_W          = $clog2(MST_AMT),
  parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
);
  logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_AxID_i;
  logic [ADDR_WIDTH*MST_AMT-1:0]        dsp_AxADDR_i;
  logic [TRANS_BURST_W*MST_AMT-1:0]     dsp_AxBURST_i;
  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]  dsp_AxLEN_i;
  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0] dsp_AxSIZE_i;
  logic [MST_AMT-1:0]                   dsp_AxVALID_i;
  logic [MST_AMT-1:0]                   dsp_AxREADY_o;

  logic [TRANS_SLV_ID_W-1:0]            s_AxID_o;
  logic [ADDR_WIDTH-1:0]                s_AxADDR_o;
  logic [TRANS_BURST_W-1:0]             s_AxBURST_o;
  logic [TRANS_DATA_LEN_W-1:0]          s_AxLEN_o;
  logic [TRANS_DATA_SIZE_W-1:0]         s_AxSIZE_o;
  logic                                 s_AxVALID_o;
  logic                                 s_AxREADY_i;

  logic                                 s_xVALID_i;
  logic                                 s_xREADY_i;
  logic                                 s_xLAST_i;

  logic [MST_ID_W-1:0]                  sa_xDATA_mst_id_o;
  logic                                 sa_xDATA_disable_o;
  logic [OUTST_CTN_W-1:0]               sa_Ax_outst_ctn_o;

  modport slave (
    input  dsp_AxID_i, dsp_AxADDR_i, dsp_AxBURST_i, dsp_AxLEN_i, dsp_AxSIZE_i,
    input  dsp_AxVALID_i,
    output dsp_AxREADY_o,
    output s_AxID_o, s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o, s_AxVALID_o,
    input  s_AxREADY_i,
    input  s_xVALID_i, s_xREADY_i, s_xLAST_i,
    output sa_xDATA_mst_id_o, sa_xDATA_disable_o, sa_Ax_outst_ctn_o
  );

  modport master (
    output dsp_AxID_i, dsp_AxADDR_i, dsp_AxBURST_i, dsp_AxLEN_i, dsp_AxSIZE_i,
    output dsp_AxVALID_i,
    input  dsp_AxREADY_o,
    input  s_AxID_o, s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o, s_AxVALID_o,
    output s_AxREADY_i,
    output s_xVALID_i, s_xREADY_i, s_xLAST_i,
    input  sa_xDATA_mst_id_o, sa_xDATA_disable_o, sa_Ax_outst_ctn_o
  );
endinterface

// File: rtl/sa_xaddr_channel.sv
// ---------------------------------------------------------------------------
// sa_xaddr_channel
// Per-slave address-channel arbiter. Picks one requesting dispatcher per
// cycle, registers the winner onto the slave AW/AR port with the master index
// prepended to the ID, and records grant order in an outstanding FIFO whose
// head tells the slave xDATA arbiter which master owns the current burst.
// Ports:
//   ACLK_i     - clock
//   ARESETn_i  - synchronous active-low reset
//   bus        - sa_xaddr_channel_if.slave (dispatcher side, slave side,
//                data-beat retire inputs and burst-ownership outputs)
// Build option:
//   SA_FIXED_PRIORITY_EN - when defined, lowest master index always wins and
//                          the round-robin pointer is not built.
// ---------------------------------------------------------------------------
module sa_xaddr_channel #(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int MST_ID_W          = $clog2(MST_AMT),
  parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
) (
  input  logic              ACLK_i,
  input  logic              ARESETn_i,
  sa_xaddr_channel_if.slave bus
);
  localparam int PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;

  // Per-master views of the packed request buses
  logic [TRANS_MST_ID_W-1:0]    req_id    [MST_AMT];
  logic [ADDR_WIDTH-1:0]        req_addr  [MST_AMT];
  logic [TRANS_BURST_W-1:0]     req_burst [MST_AMT];
  logic [TRANS_DATA_LEN_W-1:0]  req_len   [MST_AMT];
  logic [TRANS_DATA_SIZE_W-1:0] req_size  [MST_AMT];

  for (genvar gi = 0; gi < MST_AMT; gi++) begin : g_unpack
    assign req_id[gi]    = bus.dsp_AxID_i[gi*TRANS_MST_ID_W +: TRANS_MST_ID_W];
    assign req_addr[gi]  = bus.dsp_AxADDR_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_burst[gi] = bus.dsp_AxBURST_i[gi*TRANS_BURST_W +: TRANS_BURST_W];
    assign req_len[gi]   = bus.dsp_AxLEN_i[gi*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
    assign req_size[gi]  = bus.dsp_AxSIZE_i[gi*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
  end

  // Output slot registers
  logic                         s_valid_q, s_valid_d;
  logic [TRANS_SLV_ID_W-1:0]    s_id_q, s_id_d;
  logic [ADDR_WIDTH-1:0]        s_addr_q, s_addr_d;
  logic [TRANS_BURST_W-1:0]     s_burst_q, s_burst_d;
  logic [TRANS_DATA_LEN_W-1:0]  s_len_q, s_len_d;
  logic [TRANS_DATA_SIZE_W-1:0] s_size_q, s_size_d;

  // Grant-order FIFO
  logic [MST_ID_W-1:0]    fifo_q [OUTSTANDING_AMT];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OUTST_CTN_W-1:0] cnt_q, cnt_d;

  logic                slot_free, fifo_full, push, pop;
  logic                grant_vld;
  logic [MST_ID_W-1:0] grant_idx;
  logic [MST_ID_W-1:0] rr_base;
  logic [MST_AMT-1:0]  ready_onehot;

  assign slot_free = !s_valid_q || bus.s_AxREADY_i;
  assign fifo_full = (cnt_q == OUTST_CTN_W'(OUTSTANDING_AMT));

`ifdef SA_FIXED_PRIORITY_EN
  assign rr_base = '0;
`else
  logic [MST_ID_W-1:0] rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (grant_vld) begin
      rr_d = (grant_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) rr_q <= '0;
    else            rr_q <= rr_d;
  end

  assign rr_base = rr_q;
`endif

  // Search starting at rr_base, wrapping; the first requester wins. Grants
  // are suppressed while reset is asserted so no dispatcher handshake leaks.
  always_comb begin
    int cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (ARESETn_i && slot_free && !fifo_full) begin
      for (int k = 0; k < MST_AMT; k++) begin
        cand = (int'(rr_base) + k) % MST_AMT;
        if (!grant_vld && bus.dsp_AxVALID_i[cand]) begin
          grant_vld = 1'b1;
          grant_idx = MST_ID_W'(cand);
        end
      end
    end
  end

  always_comb begin
    ready_onehot = '0;
    if (grant_vld) ready_onehot[grant_idx] = 1'b1;
  end

  // Output slot: load the winner, otherwise drop valid once the slave took it
  always_comb begin
    s_valid_d = s_valid_q;
    s_id_d    = s_id_q;
    s_addr_d  = s_addr_q;
    s_burst_d = s_burst_q;
    s_len_d   = s_len_q;
    s_size_d  = s_size_q;
    if (grant_vld) begin
      s_valid_d = 1'b1;
      s_id_d    = {grant_idx, req_id[grant_idx]};
      s_addr_d  = req_addr[grant_idx];
      s_burst_d = req_burst[grant_idx];
      s_len_d   = req_len[grant_idx];
      s_size_d  = req_size[grant_idx];
    end else if (slot_free) begin
      s_valid_d = 1'b0;
    end
  end

  // FIFO bookkeeping; a pop on an empty FIFO is discarded
  assign push = grant_vld;
  assign pop  = bus.s_xVALID_i && bus.s_xREADY_i && bus.s_xLAST_i && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      s_valid_q <= 1'b0;
      s_id_q    <= '0;
      s_addr_q  <= '0;
      s_burst_q <= '0;
      s_len_q   <= '0;
      s_size_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < OUTSTANDING_AMT; i++) fifo_q[i] <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_id_q    <= s_id_d;
      s_addr_q  <= s_addr_d;
      s_burst_q <= s_burst_d;
      s_len_q   <= s_len_d;
      s_size_q  <= s_size_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      if (push) fifo_q[wr_ptr_q] <= grant_idx;
    end
  end

  assign bus.dsp_AxREADY_o      = ready_onehot;
  assign bus.s_AxVALID_o        = s_valid_q;
  assign bus.s_AxID_o           = s_id_q;
  assign bus.s_AxADDR_o         = s_addr_q;
  assign bus.s_AxBURST_o        = s_burst_q;
  assign bus.s_AxLEN_o          = s_len_q;
  assign bus.s_AxSIZE_o         = s_size_q;
  assign bus.sa_xDATA_mst_id_o  = fifo_q[rd_ptr_q];
  assign bus.sa_xDATA_disable_o = (cnt_q == '0);
  assign bus.sa_Ax_outst_ctn_o  = cnt_q;

endmodule
